pad_pattern_gen: RTL and testbench
==================================

Name: pad_pattern_gen

Overview:
- Parametrised successor to the fixed 16-bit, 4-live-bit tie-off data source.
- Drives an OUT_W-bit bus. The low LIVE_W bits carry a registered pattern: up-count, down-count, LFSR or constant. The upper bits are permanently 1'b0.
- Output uses a valid/ready handshake and supports optional finite bursts.
- Sits at test-harness and stub boundaries wherever a padded data bus needs a live, controllable low field.

Parameters:
- OUT_W, 16, total output bus width; must be >= LIVE_W.
- LIVE_W, 4, width of the live pattern field; legal range 2..16.
- BURST_LEN, 0, beats per run; 0 means run until stop.

Ports:
- in_clock  in  1  clock; all logic on the rising edge.
- in_reset  in  1  reset, synchronous, active-low.
- cfg_mode  in  2  pattern select: 0 up-count, 1 down-count, 2 LFSR, 3 constant.
- cfg_seed  in  LIVE_W  seed value for count/LFSR, or the value for constant mode.
- cfg_load  in  1  captures cfg_seed into the seed register; honoured in IDLE only.
- start  in  1  begins a run; honoured in IDLE only.
- stop  in  1  ends the run after the current beat.
- data_out  out  OUT_W  {zeros, live field}.
- data_valid  out  1  data_out holds a beat.
- data_ready  in  1  sink accepts the beat.
- busy  out  1  high in RUN or DRAIN.
- wrap  out  1  presented beat is the terminal value; qualified by data_valid.

Behaviour:
- Reset (in_reset=0 at an edge): FSM=IDLE; data_out=0; data_valid=0; busy=0; wrap=0; seed register=0; mode register=0; beat counter=0.
- data_out[OUT_W-1:LIVE_W] is 1'b0 in every cycle, including during reset.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_load=1 loads the seed register.
  - start=1 and stop=0 latches cfg_mode, moves to RUN, and loads the live field with the seed. data_valid rises the next cycle (latency 1).
  - Exception: in LFSR mode a zero seed is replaced by 1.
- RUN: a transfer occurs when data_valid and data_ready are both 1. On each transfer the live field advances:
  - up: +1 mod 2^LIVE_W.
  - down: -1 mod 2^LIVE_W.
  - LFSR: Fibonacci shift-left, feedback = XOR of the tap bits into bit 0.
  - constant: unchanged.
- Stall: while data_valid=1 and data_ready=0, data_out and wrap hold stable.
- wrap=1 while the presented value is the terminal value:
  - up: all-ones.
  - down: 0.
  - LFSR: the value preceding a return to the seed.
  - constant: never.
- stop:
  - Seen with no pending beat: go to IDLE next cycle with data_valid=0.
  - Seen while a beat is stalled: go to DRAIN; hold the beat until transferred, then go to IDLE. No further beats are produced.
  - start and stop in the same IDLE cycle: stop wins and the FSM stays in IDLE.
- BURST_LEN>0: the beat counter increments per transfer. The transfer of beat BURST_LEN returns the FSM to IDLE; data_valid=0 in the following cycle.
- Ignored inputs: start in RUN or DRAIN is ignored. cfg_mode, cfg_seed and cfg_load outside IDLE are ignored.
- Reset mid-run: immediate return to the reset state at the next edge; any pending beat is dropped.
- Beat counter width: $clog2(BURST_LEN+1), minimum 1.

Decomposition:
- Shared package pad_gen_pkg holds:
  - mode enum (MODE_UP, MODE_DOWN, MODE_LFSR, MODE_CONST);
  - FSM state enum;
  - function lfsr_taps(width) returning maximal-length tap masks for widths 2..16.
- One sub-module, pad_lfsr_step: combinational next-value for the LFSR, parametrised by LIVE_W.
- Counter stepping stays inline.

Test Plan:
- Reset, then idle 5 cycles -> data_out=16'h0000, data_valid=0, busy=0 throughout.
- Up-count: load seed 4'hE, mode 0, start, ready=1 -> live field 4'hE, 4'hF (wrap=1), 4'h0, 4'h1. data_out[15:4]=0 on every beat.
- Stall: ready=0 for 3 cycles mid-stream at value 4'h5 -> data_out holds 16'h0005 with valid=1. When ready rises, the next beat is 4'h6.
- LFSR, LIVE_W=4: seed 0 -> first value 4'h1. Sequence has period 15 with no repeats, and wrap pulses once per period.
- BURST_LEN=3, down mode, seed 4'h2 -> beats 2, 1, 0 (wrap on 0). Then valid=0 and busy=0 in the next cycle.
- Stop during stall, then in_reset=0 during a subsequent run -> first case: beat held until ready, then IDLE. Second case: all outputs 0 at the next edge.

Source files
------------

// File: rtl/pad_gen_pkg.sv
// Shared types and constants for the padded pattern generator.
// Holds the pattern modes, the FSM states and the LFSR tap table.
package pad_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Maximal-length masks for a shift-left Fibonacci LFSR; bit i set means
  // state bit i feeds the XOR that becomes the new bit 0.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0003;
    endcase
  endfunction

endpackage

// File: rtl/pad_lfsr_step.sv
// Combinational next-value of a LIVE_W-bit shift-left Fibonacci LFSR.
module pad_lfsr_step
  import pad_gen_pkg::*;
#(
  parameter int LIVE_W = 4
) (
  input  logic [LIVE_W-1:0] cur,
  output logic [LIVE_W-1:0] nxt
);

  localparam logic [15:0]       TAPS_ALL = lfsr_taps(LIVE_W);
  localparam logic [LIVE_W-1:0] TAPS     = TAPS_ALL[LIVE_W-1:0];

  assign nxt = {cur[LIVE_W-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/pad_pattern_gen.sv
// Padded data source: a live low field (count/LFSR/constant) under a
// valid/ready handshake, upper bus bits tied to zero, optional finite bursts.
module pad_pattern_gen
  import pad_gen_pkg::*;
#(
  parameter int OUT_W     = 16,
  parameter int LIVE_W    = 4,
  parameter int BURST_LEN = 0
) (
  input  logic              in_clock,
  input  logic              in_reset,
  input  logic [1:0]        cfg_mode,
  input  logic [LIVE_W-1:0] cfg_seed,
  input  logic              cfg_load,
  input  logic              start,
  input  logic              stop,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              wrap
);

  localparam int                CNT_W    = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
  localparam logic [LIVE_W-1:0] ONE      = LIVE_W'(1);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [LIVE_W-1:0]   live_q, live_d;
  logic [LIVE_W-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [LIVE_W-1:0]   lfsr_nxt;
  logic [LIVE_W-1:0]   step_val;
  logic [LIVE_W-1:0]   start_val;
  logic [LIVE_W-1:0]   lfsr_origin;
  logic                xfer;
  logic                last_beat;
  logic                terminal;

  pad_lfsr_step #(.LIVE_W(LIVE_W)) u_lfsr_step (
    .cur (live_q),
    .nxt (lfsr_nxt)
  );

  assign xfer      = data_valid && data_ready;
  assign last_beat = (BURST_LEN > 0) && (cnt_q == LAST_CNT);

  // A same-cycle cfg_load is forwarded so load+start starts from the new seed.
  always_comb begin
    start_val = cfg_load ? cfg_seed : seed_q;
    if ((mode_t'(cfg_mode) == MODE_LFSR) && (start_val == '0)) start_val = ONE;
  end

  // seed_q cannot change during a run, so it still names the LFSR origin.
  assign lfsr_origin = (seed_q == '0) ? ONE : seed_q;

  always_comb begin
    step_val = live_q;
    terminal = 1'b0;
    case (mode_q)
      MODE_UP:   begin step_val = live_q + ONE; terminal = (live_q == '1);        end
      MODE_DOWN: begin step_val = live_q - ONE; terminal = (live_q == '0);        end
      MODE_LFSR: begin step_val = lfsr_nxt;     terminal = (lfsr_nxt == lfsr_origin); end
      default:   begin step_val = live_q;       terminal = 1'b0;                  end
    endcase
  end

  // NOTE: every signal gets its default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    live_d  = live_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_load) seed_d = cfg_seed;
        if (start && !stop) begin
          state_d = ST_RUN;
          mode_d  = mode_t'(cfg_mode);
          live_d  = start_val;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          live_d = step_val;
          cnt_d  = cnt_q + CNT_W'(1);
          if (stop || last_beat) state_d = ST_IDLE;
        end else if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      live_q  <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      live_q  <= live_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_valid = (state_q != ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign wrap       = data_valid && terminal;
  assign data_out   = OUT_W'(data_valid ? live_q : '0);

endmodule

// File: tb/tb_pad_pattern_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a
// beat-level reference model, on a free-running and a 3-beat burst instance.
module tb_pad_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [3:0]  cfg_seed = 4'h0;
  logic        cfg_load = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        stop = 1'b0;
  logic        ready = 1'b0;

  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b, wrap_a, wrap_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pad_pattern_gen #(.OUT_W(16), .LIVE_W(4), .BURST_LEN(0)) dut_a (
    .in_clock(clk), .in_reset(rst_n), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .cfg_load(cfg_load), .start(start_a), .stop(stop), .data_out(data_a),
    .data_valid(valid_a), .data_ready(ready), .busy(busy_a), .wrap(wrap_a)
  );

  pad_pattern_gen #(.OUT_W(16), .LIVE_W(4), .BURST_LEN(3)) dut_b (
    .in_clock(clk), .in_reset(rst_n), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .cfg_load(cfg_load), .start(start_b), .stop(stop), .data_out(data_b),
    .data_valid(valid_b), .data_ready(ready), .busy(busy_b), .wrap(wrap_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, whether a beat is on offer, whether the
  // run is draining, the presented value and the run's bookkeeping.
  int unsigned burst[2] = '{0, 3};
  int unsigned m_act[2], m_drain[2], m_val[2], m_mode[2], m_seed[2], m_origin[2], m_cnt[2];

  function automatic int unsigned lfsr_ref(input int unsigned v);
    return ((v << 1) | (((v >> 3) ^ (v >> 2)) & 1)) & 15;
  endfunction

  function automatic int unsigned advance(input int unsigned mode, input int unsigned v);
    case (mode)
      0:       return (v + 1) % 16;
      1:       return (v + 15) % 16;
      2:       return lfsr_ref(v);
      default: return v;
    endcase
  endfunction

  function automatic bit is_terminal(input int i);
    case (m_mode[i])
      0:       return m_val[i] == 15;
      1:       return m_val[i] == 0;
      2:       return lfsr_ref(m_val[i]) == m_origin[i];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit st;
      int unsigned sv;
      st = (i == 0) ? start_a : start_b;
      if (!rst_n) begin
        m_act[i] = 0; m_drain[i] = 0; m_val[i] = 0; m_mode[i] = 0;
        m_seed[i] = 0; m_origin[i] = 0; m_cnt[i] = 0;
      end else if (m_act[i] == 0) begin
        sv = cfg_load ? cfg_seed : m_seed[i];
        if (cfg_load) m_seed[i] = cfg_seed;
        if (st && !stop) begin
          if (cfg_mode == 2 && sv == 0) sv = 1;
          m_act[i] = 1; m_drain[i] = 0; m_mode[i] = cfg_mode;
          m_val[i] = sv; m_origin[i] = sv; m_cnt[i] = 0;
        end
      end else if (ready) begin
        m_cnt[i]++;
        m_val[i] = advance(m_mode[i], m_val[i]);
        if (stop || m_drain[i] != 0 || (burst[i] > 0 && m_cnt[i] == burst[i])) begin
          m_act[i] = 0; m_drain[i] = 0;
        end
      end else if (stop) begin
        m_drain[i] = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("a.data",  data_a,  m_act[0] != 0 ? m_val[0] : 0);
    check("a.valid", valid_a, m_act[0] != 0);
    check("a.busy",  busy_a,  m_act[0] != 0);
    check("a.wrap",  wrap_a,  m_act[0] != 0 && is_terminal(0));
    check("b.data",  data_b,  m_act[1] != 0 ? m_val[1] : 0);
    check("b.valid", valid_b, m_act[1] != 0);
    check("b.busy",  busy_b,  m_act[1] != 0);
    check("b.wrap",  wrap_b,  m_act[1] != 0 && is_terminal(1));
  endtask

  // Inputs change 1ns after a rising edge and are sampled at the next one.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    bit   seen[16];
    int   dups, wraps;
    logic [3:0] v;

    tick(); tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("idle.data", data_a, 16'h0000);
      check("idle.valid", valid_a, 1'b0);
      check("idle.busy", busy_a, 1'b0);
    end

    // Up-count from 4'hE through the wrap, then a 3-cycle stall at 5.
    cfg_load = 1; cfg_seed = 4'hE; tick();
    cfg_load = 0; cfg_mode = 2'd0; start_a = 1; tick();
    start_a = 0;
    check("up.first", data_a, 16'h000E);
    check("up.first_valid", valid_a, 1'b1);
    ready = 1; tick();
    check("up.F", data_a, 16'h000F);
    check("up.F_wrap", wrap_a, 1'b1);
    tick(); check("up.0", data_a, 16'h0000); check("up.0_wrap", wrap_a, 1'b0);
    tick(); check("up.1", data_a, 16'h0001);
    repeat (4) tick();
    check("up.5", data_a, 16'h0005);
    ready = 0;
    repeat (3) begin
      tick();
      check("stall.hold", data_a, 16'h0005);
      check("stall.valid", valid_a, 1'b1);
    end
    ready = 1; tick();
    check("stall.next", data_a, 16'h0006);
    stop = 1; tick(); stop = 0;
    check("stop.valid", valid_a, 1'b0);
    check("stop.busy", busy_a, 1'b0);

    // LFSR from a zero seed: starts at 1, period 15, one wrap per period.
    cfg_load = 1; cfg_seed = 4'h0; tick();
    cfg_load = 0; cfg_mode = 2'd2; start_a = 1; tick();
    start_a = 0;
    check("lfsr.first", data_a, 16'h0001);
    foreach (seen[k]) seen[k] = 1'b0;
    dups = 0; wraps = 0;
    for (int k = 0; k < 15; k++) begin
      v = data_a[3:0];
      if (seen[v]) dups++;
      seen[v] = 1'b1;
      if (wrap_a) wraps++;
      tick();
    end
    check("lfsr.period", data_a, 16'h0001);
    check("lfsr.no_repeat", dups, 0);
    check("lfsr.wraps", wraps, 1);
    check("lfsr.no_zero", seen[0], 1'b0);
    stop = 1; tick(); stop = 0;

    // Three-beat burst counting down from 2.
    cfg_load = 1; cfg_seed = 4'h2; tick();
    cfg_load = 0; cfg_mode = 2'd1; start_b = 1; tick();
    start_b = 0;
    check("burst.2", data_b, 16'h0002);
    tick(); check("burst.1", data_b, 16'h0001);
    tick(); check("burst.0", data_b, 16'h0000); check("burst.0_wrap", wrap_b, 1'b1);
    tick();
    check("burst.end_valid", valid_b, 1'b0);
    check("burst.end_busy", busy_b, 1'b0);

    // Stop while stalled: beat held (start ignored) until it transfers.
    ready = 0; cfg_load = 1; cfg_seed = 4'h3; cfg_mode = 2'd0; start_a = 1; tick();
    cfg_load = 0; start_a = 0;
    check("drain.first", data_a, 16'h0003);
    stop = 1; tick(); stop = 0;
    check("drain.busy", busy_a, 1'b1);
    check("drain.hold", data_a, 16'h0003);
    start_a = 1; tick(); start_a = 0;
    check("drain.still", data_a, 16'h0003);
    ready = 1; tick();
    check("drain.done_valid", valid_a, 1'b0);
    check("drain.done_busy", busy_a, 1'b0);

    // start and stop together in IDLE: stays idle.
    start_a = 1; stop = 1; tick(); start_a = 0; stop = 0;
    check("startstop.busy", busy_a, 1'b0);

    // Reset mid-run drops the beat at the next edge.
    start_a = 1; tick(); start_a = 0;
    tick(); tick();
    rst_n = 0; tick();
    check("rst.data", data_a, 16'h0000);
    check("rst.valid", valid_a, 1'b0);
    check("rst.busy", busy_a, 1'b0);
    check("rst.wrap", wrap_a, 1'b0);
    rst_n = 1; tick();

    repeat (800) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      cfg_load = ($urandom_range(0, 3) == 0);
      cfg_seed = 4'($urandom_range(0, 15));
      cfg_mode = 2'($urandom_range(0, 3));
      start_a  = ($urandom_range(0, 2) == 0);
      start_b  = ($urandom_range(0, 2) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      ready    = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
